trace_capture_sequencer: RTL
============================

Name: trace_capture_sequencer

Overview:
- Sequences one side-channel measurement run for the on-chip sensor path.
- Takes a UART command byte, programs the IDELAY tap and pulses the AES cores' start.
- Records one processed TDC sample per cycle into a trace buffer, marking AES completion in the trace.
- Streams a framed trace to the UART TX via a valid/ready byte handshake, then holds off before accepting the next command.

Parameters:
DEPTH_LOG2, 10, trace buffer depth = 2^DEPTH_LOG2 samples
DATA_W, 8, sample width (fixed 8 for UART framing; other values unsupported)
HOLDOFF, 4096, idle cycles after a frame before the next command is accepted (>=1)

Ports:
clk  in  1  single clock; sensor, AES handshake and UART side are all in this domain
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  one-cycle strobe, cmd_byte valid
cmd_byte  in  8  command from UART RX
aes_start  out  1  one-cycle start pulse to AES cores
aes_done  in  1  AES completion (level, AND of all cores)
sample  in  8  processed sensor sample, sampled every cycle in CAPTURE
delay_tap  out  5  IDELAY CNTVALUEIN
tx_valid  out  1  byte available to UART TX
tx_byte  out  8  byte to transmit
tx_ready  in  1  UART TX accepts byte this cycle
busy  out  1  high from ARM through HOLDOFF
timeout  out  1  last run saw no aes_done during capture

Behaviour:
- Reset (async, rstn=0): state=IDLE; aes_start=0, tx_valid=0, tx_byte=0, delay_tap=0, busy=0, timeout=0, write/read address=0. Buffer contents are undefined.
- Effect is immediate, including mid-capture or mid-frame: tx_valid drops without completing the current byte.
- IDLE, command decode (only when cmd_valid=1; all other cycles and all non-IDLE states ignore commands):
  - 0..31: delay_tap<=cmd_byte; go to ARM.
  - 250: delay_tap<=delay_tap+1 mod 32 (31 wraps to 0); go to ARM.
  - Any other value: ignored, stay in IDLE.
- ARM (1 cycle): aes_start=1, busy=1, timeout<=0, waddr<=0, done_seen<=0; next state CAPTURE.
- CAPTURE (exactly 2^DEPTH_LOG2 cycles, first cycle immediately after ARM):
  - Each cycle writes mem[waddr]; waddr increments.
  - Written value: 0xFF if aes_done=1 that cycle; otherwise sample, saturated so that a raw 0xFF is stored as 0xFE. 0xFF is therefore a unique completion marker.
  - aes_done=1 in any capture cycle sets done_seen.
  - On the last write (waddr = max): timeout<=~done_seen; raddr<=0; go to DUMP.
- DUMP: frame is 0xA5, then delay_tap, then mem[0..2^DEPTH_LOG2-1] in order, 2^DEPTH_LOG2+2 bytes total.
  - Memory read is registered (1-cycle latency); prefetch so no bubble is required, but bubbles with tx_valid=0 are permitted.
  - Handshake: a byte transfers when tx_valid and tx_ready are both 1 on a clock edge.
  - While tx_valid=1 and tx_ready=0, tx_byte is held stable and tx_valid stays 1.
  - tx_ready while tx_valid=0 is ignored.
  - No byte may be dropped or duplicated.
  - After the last trace byte transfers: tx_valid<=0; go to HOLDOFF.
- HOLDOFF: counts HOLDOFF cycles with busy=1, then IDLE with busy=0.
- aes_done during IDLE/DUMP/HOLDOFF: ignored. aes_start is never asserted outside ARM.
- delay_tap is stable from ARM until the next accepted command.

Test Plan:
- Reset, cmd 0x05, sample = low 8 bits of capture cycle index, aes_done high at capture cycles 100..101:
  - delay_tap=5; single aes_start pulse; busy rises with ARM.
  - Frame is A5,05, then trace bytes 00..63, FF, FF, 66.. with wrap, 1026 bytes total; timeout=0.
- Sample held at 0xFF, aes_done at cycle 10 -> trace bytes are all FE except byte index 10 = FF.
- Tap preset to 31 via cmd 0x1F, complete run and holdoff, then cmd 250 -> delay_tap=0; header bytes A5,00.
- aes_done held 0 for a full run -> timeout=1 at entry to DUMP; full frame still sent; timeout clears at the next ARM.
- tx_ready toggled randomly, including a 50-cycle low stretch mid-frame -> tx_byte stable while stalled; received sequence identical to the no-stall case; exactly 1026 transfers.
- cmd_valid pulsed during CAPTURE, DUMP and HOLDOFF -> no effect. rstn pulsed low mid-DUMP -> all outputs return to reset values immediately; next cmd 0x03 yields a fresh, complete frame with header A5,03.

Source files
------------

// File: rtl/trace_capture_sequencer.sv
// Side-channel capture run sequencer: command decode, AES start, trace capture
// into an on-chip buffer, framed byte streaming to UART TX, then a holdoff.
//
// state     | meaning
// S_IDLE    | waiting for a tap command
// S_ARM     | one-cycle AES start, clears run status
// S_CAPTURE | one trace sample written per cycle
// S_DUMP    | streaming A5, tap, trace bytes over valid/ready
// S_HOLDOFF | quiet period before the next command is accepted
module trace_capture_sequencer #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 8,
    parameter int HOLDOFF    = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_byte,
    output logic              aes_start,
    input  logic              aes_done,
    input  logic [DATA_W-1:0] sample,
    output logic [4:0]        delay_tap,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_byte,
    input  logic              tx_ready,
    output logic              busy,
    output logic              timeout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 2;
    localparam int HW    = $clog2(HOLDOFF) + 1;
    localparam logic [CW-1:0] FRAME_LEN = CW'(DEPTH + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DUMP,
        S_HOLDOFF
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        tap_q, tap_d;
    logic              timeout_q, timeout_d;
    logic              done_seen_q, done_seen_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        timeout_d   = timeout_q;
        done_seen_d = done_seen_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        cnt_d       = cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_byte_d   = tx_byte_q;
        hold_d      = hold_q;
        mem_we      = 1'b0;
        // all-ones is reserved as the AES completion marker
        if (aes_done)
            mem_wdata = '1;
        else if (&sample)
            mem_wdata = {{(DATA_W-1){1'b1}}, 1'b0};
        else
            mem_wdata = sample;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_byte < 8'd32) begin
                        tap_d   = cmd_byte[4:0];
                        state_d = S_ARM;
                    end else if (cmd_byte == 8'd250) begin
                        tap_d   = tap_q + 5'd1;
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                timeout_d   = 1'b0;
                done_seen_d = 1'b0;
                waddr_d     = '0;
                state_d     = S_CAPTURE;
            end
            S_CAPTURE: begin
                mem_we      = 1'b1;
                waddr_d     = waddr_q + AW'(1);
                done_seen_d = done_seen_q | aes_done;
                if (waddr_q == '1) begin
                    timeout_d = ~(done_seen_q | aes_done);
                    raddr_d   = '0;
                    cnt_d     = '0;
                    state_d   = S_DUMP;
                end
            end
            S_DUMP: begin
                if (tx_valid_q && tx_ready && cnt_q == FRAME_LEN) begin
                    tx_valid_d = 1'b0;
                    hold_d     = HW'(HOLDOFF - 1);
                    state_d    = S_HOLDOFF;
                end else if ((!tx_valid_q || tx_ready) && cnt_q != FRAME_LEN) begin
                    // rd_data_q already holds mem[raddr_q], so trace bytes load back to back
                    tx_valid_d = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                    if (cnt_q == '0) begin
                        tx_byte_d = DATA_W'(8'hA5);
                    end else if (cnt_q == CW'(1)) begin
                        tx_byte_d = DATA_W'(tap_q);
                    end else begin
                        tx_byte_d = rd_data_q;
                        raddr_d   = raddr_q + AW'(1);
                    end
                end
            end
            S_HOLDOFF: begin
                if (hold_q == '0)
                    state_d = S_IDLE;
                else
                    hold_d = hold_q - HW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            timeout_q   <= 1'b0;
            done_seen_q <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            cnt_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            timeout_q   <= timeout_d;
            done_seen_q <= done_seen_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            cnt_q       <= cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            hold_q      <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[waddr_q] <= mem_wdata;
        rd_data_q <= mem[raddr_d];
    end

    assign aes_start = (state_q == S_ARM);
    assign busy      = (state_q != S_IDLE);
    assign timeout   = timeout_q;
    assign delay_tap = tap_q;
    assign tx_valid  = tx_valid_q;
    assign tx_byte   = tx_byte_q;

endmodule
